instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port i_readM  output  1  instruction-memory read request.
REQ-004 SHALL have port i_address  output  16  instruction-memory word address.
REQ-005 SHALL have port i_data  input  16  instruction-memory read data, valid when inputReady=1.
REQ-006 SHALL have port inputReady  input  1  memory completion strobe, one cycle per request.
REQ-007 SHALL have port IFID_WriteEn  input  1  IF/ID register load enable; 0 = decode stall.
REQ-008 SHALL have port redirect  input  1  taken branch/jump: discard fetch, restart at redirect_target.
REQ-009 SHALL have port redirect_target  input  16  new PC when redirect=1.
REQ-010 SHALL have port IF_PC4  output  16  PC+1 of the presented instruction (word-addressed).
REQ-011 SHALL have port IF_instruction  output  16  presented instruction.
REQ-012 SHALL have port IF_flush  output  1  1 = no valid instruction; IF/ID loads bubble.

Function
REQ-013 SHALL hold registers PC[15:0], req_addr[15:0], buf[15:0], state in {FETCH, HOLD, DROP}.
REQ-014 FETCH: i_readM=1, i_address=req_addr (=PC); held stable until inputReady=1 sampled.
REQ-015 FETCH, inputReady=1: IF_instruction=i_data, IF_PC4=PC+1, IF_flush=0 in that same cycle (zero-latency pass-through).
REQ-016 FETCH, inputReady=1, IFID_WriteEn=1, no redirect: PC<=PC+1, req_addr<=PC+1, stay FETCH.
REQ-017 FETCH, inputReady=1, IFID_WriteEn=0, no redirect: buf<=i_data, go HOLD, PC unchanged.
REQ-018 FETCH, inputReady=0: IF_flush=1, IF_instruction=16'hb000, IF_PC4=16'h0000.
REQ-019 HOLD: i_readM=0; IF_instruction=buf, IF_PC4=PC+1, IF_flush=0, stable while IFID_WriteEn=0.
REQ-020 HOLD, IFID_WriteEn=1: PC<=PC+1, req_addr<=PC+1, go FETCH.
REQ-021 DROP: i_readM=1, i_address=req_addr (abandoned address); IF_flush=1; i_data ignored.
REQ-022 DROP, inputReady=1: req_addr<=PC, go FETCH.
REQ-023 redirect=1 has priority over all other events; in that cycle IF_flush=1, IF_instruction=16'hb000, IF_PC4=16'h0000.
REQ-024 redirect in FETCH with inputReady=1 or in HOLD: PC<=target, req_addr<=target, go FETCH; fetched data discarded.
REQ-025 redirect in FETCH with inputReady=0: PC<=target, req_addr unchanged, go DROP.
REQ-026 redirect in DROP: PC<=target, stay DROP; response still drained.
REQ-027 PC+1 SHALL wrap 16'hFFFF -> 16'h0000; no carry out.
REQ-028 At most one outstanding memory request at any time.
REQ-029 inputReady outside FETCH/DROP SHALL be ignored.

Reset
REQ-030 reset_n=0 SHALL immediately force PC=0, req_addr=0, buf=0, state=FETCH, independent of clk.
REQ-031 While reset_n=0: i_readM=0, IF_flush=1, IF_instruction=16'hb000, IF_PC4=16'h0000.
REQ-032 Reset mid-request SHALL abandon it with no drain; first request after release is to address 0.

Verification
REQ-033 Reset release, memory 1-cycle ready, IFID_WriteEn=1 -> i_address 0,1,2 on consecutive cycles; IF_PC4 1,2,3; IF_flush=0 each.
REQ-034 Ready after 3 cycles at addr 5, data 16'h1234 -> IF_flush=1 two cycles, then IF_instruction=16'h1234, IF_PC4=6.
REQ-035 Data 16'hABCD ready while IFID_WriteEn=0 for 4 cycles -> i_readM=0, outputs stable ABCD; WriteEn=1 -> next i_address=PC+1.
REQ-036 redirect to 16'h0040 while request at 16'h0010 pending -> i_address stays 0010 until inputReady, data dropped (IF_flush=1), next request 0040.
REQ-037 PC=16'hFFFF fetched and consumed -> IF_PC4=16'h0000, next i_address=16'h0000.
REQ-038 reset_n pulsed low mid-HOLD, between clock edges -> outputs go to reset values asynchronously; after release fetch restarts at 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: one outstanding word-addressed memory request, a hold
// buffer for decode stalls, and a drop state that drains responses made stale by redirects.
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        reset_n,
  output logic        i_readM,
  output logic [15:0] i_address,
  input  logic [15:0] i_data,
  input  logic        inputReady,
  input  logic        IFID_WriteEn,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic [15:0] IF_PC4,
  output logic [15:0] IF_instruction,
  output logic        IF_flush
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  localparam logic [15:0] BUBBLE_INSTR = 16'hb000;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_req_addr;
  logic [15:0] r_buf;

  state_t      w_state_nxt;
  logic [15:0] w_pc_nxt;
  logic [15:0] w_req_addr_nxt;
  logic [15:0] w_buf_nxt;
  logic [15:0] w_pc_inc;

  assign w_pc_inc = r_pc + 16'd1;

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_addr_nxt = r_req_addr;
    w_buf_nxt      = r_buf;
    i_readM        = 1'b0;
    i_address      = r_req_addr;
    IF_instruction = BUBBLE_INSTR;
    IF_PC4         = 16'h0000;
    IF_flush       = 1'b1;

    case (r_state)
      FETCH: begin
        i_readM = 1'b1;
        if (inputReady) begin
          IF_instruction = i_data;
          IF_PC4         = w_pc_inc;
          IF_flush       = 1'b0;
          if (redirect) begin
            w_pc_nxt       = redirect_target;
            w_req_addr_nxt = redirect_target;
          end else if (IFID_WriteEn) begin
            w_pc_nxt       = w_pc_inc;
            w_req_addr_nxt = w_pc_inc;
          end else begin
            w_buf_nxt   = i_data;
            w_state_nxt = HOLD;
          end
        end else if (redirect) begin
          // Request is still in flight: keep its address, discard its response later.
          w_pc_nxt    = redirect_target;
          w_state_nxt = DROP;
        end
      end

      HOLD: begin
        IF_instruction = r_buf;
        IF_PC4         = w_pc_inc;
        IF_flush       = 1'b0;
        if (redirect) begin
          w_pc_nxt       = redirect_target;
          w_req_addr_nxt = redirect_target;
          w_state_nxt    = FETCH;
        end else if (IFID_WriteEn) begin
          w_pc_nxt       = w_pc_inc;
          w_req_addr_nxt = w_pc_inc;
          w_state_nxt    = FETCH;
        end
      end

      DROP: begin
        i_readM = 1'b1;
        if (redirect) w_pc_nxt = redirect_target;
        // The stale response completes the one outstanding request; resume at the latest PC.
        if (inputReady) begin
          w_req_addr_nxt = w_pc_nxt;
          w_state_nxt    = FETCH;
        end
      end

      default: w_state_nxt = FETCH;
    endcase

    if (redirect) begin
      IF_instruction = BUBBLE_INSTR;
      IF_PC4         = 16'h0000;
      IF_flush       = 1'b1;
    end

    // Reset must reach the outputs without waiting for a clock edge.
    if (!reset_n) begin
      i_readM        = 1'b0;
      IF_instruction = BUBBLE_INSTR;
      IF_PC4         = 16'h0000;
      IF_flush       = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= FETCH;
      r_pc       <= 16'h0000;
      r_req_addr <= 16'h0000;
      r_buf      <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_buf      <= w_buf_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: expected bus/output values are queued
// as each cycle's memory and pipeline stimulus is driven, then popped and compared mid-cycle.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        inputReady;
  logic        IFID_WriteEn;
  logic        redirect;
  logic [15:0] redirect_target;
  logic [15:0] IF_PC4;
  logic [15:0] IF_instruction;
  logic        IF_flush;

  typedef struct packed {
    logic        readm;
    logic [15:0] addr;
    logic        flush;
    logic [15:0] instr;
    logic [15:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_readM         (i_readM),
    .i_address       (i_address),
    .i_data          (i_data),
    .inputReady      (inputReady),
    .IFID_WriteEn    (IFID_WriteEn),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .IF_PC4          (IF_PC4),
    .IF_instruction  (IF_instruction),
    .IF_flush        (IF_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return a ^ 16'h5a5a;
  endfunction

  function automatic exp_t mk(input logic readm, input logic [15:0] addr, input logic flush,
                              input logic [15:0] instr, input logic [15:0] pc4);
    exp_t e;
    e.readm = readm;
    e.addr  = addr;
    e.flush = flush;
    e.instr = instr;
    e.pc4   = pc4;
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 16'd1, 16'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " i_readM"},        {15'd0, i_readM},  {15'd0, e.readm});
    check({tag, " i_address"},      i_address,         e.addr);
    check({tag, " IF_flush"},       {15'd0, IF_flush}, {15'd0, e.flush});
    check({tag, " IF_instruction"}, IF_instruction,    e.instr);
    check({tag, " IF_PC4"},         IF_PC4,            e.pc4);
  endtask

  // One clock cycle: drive inputs just after the rising edge, compare at the falling edge.
  task automatic drive(input string tag, input logic rdy, input logic [15:0] data,
                       input logic we, input logic redir, input logic [15:0] tgt,
                       input exp_t e);
    inputReady      = rdy;
    i_data          = data;
    IFID_WriteEn    = we;
    redirect        = redir;
    redirect_target = tgt;
    exp_q.push_back(e);
    @(negedge clk);
    compare_outputs(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n         = 1'b0;
    i_data          = 16'h0000;
    inputReady      = 1'b0;
    IFID_WriteEn    = 1'b1;
    redirect        = 1'b0;
    redirect_target = 16'h0000;

    #3;
    exp_q.push_back(mk(1'b0, 16'h0000, 1'b1, 16'hb000, 16'h0000));
    compare_outputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Back-to-back single-cycle fetches from address 0.
    for (int a = 0; a < 5; a++)
      drive("stream", 1'b1, mem(16'(a)), 1'b1, 1'b0, 16'h0,
            mk(1'b1, 16'(a), 1'b0, mem(16'(a)), 16'(a + 1)));

    // Slow memory at address 5.
    drive("wait5_a", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, mk(1'b1, 16'h0005, 1'b1, 16'hb000, 16'h0000));
    drive("wait5_b", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, mk(1'b1, 16'h0005, 1'b1, 16'hb000, 16'h0000));
    drive("ready5",  1'b1, 16'h1234, 1'b1, 1'b0, 16'h0, mk(1'b1, 16'h0005, 1'b0, 16'h1234, 16'h0006));

    // Decode stall on arrival at address 6, then release.
    drive("stall_in", 1'b1, 16'habcd, 1'b0, 1'b0, 16'h0, mk(1'b1, 16'h0006, 1'b0, 16'habcd, 16'h0007));
    for (int i = 0; i < 3; i++)
      drive("hold", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, mk(1'b0, 16'h0006, 1'b0, 16'habcd, 16'h0007));
    drive("hold_stray_rdy", 1'b1, 16'hffff, 1'b0, 1'b0, 16'h0, mk(1'b0, 16'h0006, 1'b0, 16'habcd, 16'h0007));
    drive("hold_release", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, mk(1'b0, 16'h0006, 1'b0, 16'habcd, 16'h0007));
    for (int a = 7; a < 16; a++)
      drive("after_hold", 1'b1, mem(16'(a)), 1'b1, 1'b0, 16'h0,
            mk(1'b1, 16'(a), 1'b0, mem(16'(a)), 16'(a + 1)));

    // Redirect while the request at 0x0010 is still pending: its response is dropped.
    drive("pend10",   1'b0, 16'h0, 1'b1, 1'b0, 16'h0,    mk(1'b1, 16'h0010, 1'b1, 16'hb000, 16'h0000));
    drive("redir40",  1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, mk(1'b1, 16'h0010, 1'b1, 16'hb000, 16'h0000));
    drive("drop_wait",1'b0, 16'h0, 1'b1, 1'b0, 16'h0,    mk(1'b1, 16'h0010, 1'b1, 16'hb000, 16'h0000));
    drive("drop_rdy", 1'b1, mem(16'h0010), 1'b1, 1'b0, 16'h0, mk(1'b1, 16'h0010, 1'b1, 16'hb000, 16'h0000));
    drive("fetch40",  1'b1, mem(16'h0040), 1'b1, 1'b0, 16'h0,
          mk(1'b1, 16'h0040, 1'b0, mem(16'h0040), 16'h0041));

    // Redirect coincident with a completed fetch, to the top of the address space.
    drive("redir_ffff", 1'b1, mem(16'h0041), 1'b1, 1'b1, 16'hffff, mk(1'b1, 16'h0041, 1'b1, 16'hb000, 16'h0000));
    drive("fetch_ffff", 1'b1, mem(16'hffff), 1'b1, 1'b0, 16'h0,
          mk(1'b1, 16'hffff, 1'b0, mem(16'hffff), 16'h0000));
    drive("wrap0",      1'b1, mem(16'h0000), 1'b1, 1'b0, 16'h0, mk(1'b1, 16'h0000, 1'b0, mem(16'h0000), 16'h0001));

    // Redirect out of a decode stall.
    drive("stall1",      1'b1, 16'h5555, 1'b0, 1'b0, 16'h0,    mk(1'b1, 16'h0001, 1'b0, 16'h5555, 16'h0002));
    drive("redir_hold",  1'b0, 16'h0,    1'b0, 1'b1, 16'h0100, mk(1'b0, 16'h0001, 1'b1, 16'hb000, 16'h0000));
    drive("fetch100",    1'b1, mem(16'h0100), 1'b1, 1'b0, 16'h0,
          mk(1'b1, 16'h0100, 1'b0, mem(16'h0100), 16'h0101));

    // Asynchronous reset pulse in the middle of a HOLD, between clock edges.
    drive("stall101", 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0, mk(1'b1, 16'h0101, 1'b0, 16'h7777, 16'h0102));
    inputReady   = 1'b0;
    IFID_WriteEn = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(mk(1'b0, 16'h0000, 1'b1, 16'hb000, 16'h0000));
    compare_outputs("async_reset");
    #1;
    reset_n = 1'b1;
    drive("restart0", 1'b1, mem(16'h0000), 1'b1, 1'b0, 16'h0, mk(1'b1, 16'h0000, 1'b0, mem(16'h0000), 16'h0001));
    drive("restart1", 1'b1, mem(16'h0001), 1'b1, 1'b0, 16'h0, mk(1'b1, 16'h0001, 1'b0, mem(16'h0001), 16'h0002));

    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
